// File: rtl/rgb565_lcd_pkg.sv
// Shared types and constants for the RGB565 8080-bus LCD writer.
// Holds the FSM state enum, panel opcodes, bar colours and the pixel pack function.
package rgb565_lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_PIX    = 2'd2,
    ST_RESYNC = 2'd3
  } state_t;

  localparam logic [7:0] OP_CASET = 8'h2A;
  localparam logic [7:0] OP_PASET = 8'h2B;
  localparam logic [7:0] OP_RAMWR = 8'h2C;

  localparam int PRE_LEN = 11;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] rgb888_to_565(input logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rgb565_lcd_writer_strobe.sv
// Single-word write engine for the 8080 bus: holds one word and plays out
// WR_CYCLES clocks of wr_n low followed by WR_CYCLES clocks high.
module lcd_write_strobe #(
  parameter int WR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] word,
  input  logic        word_dc,
  output logic        free,
  output logic        idle,
  output logic [15:0] lcd_data,
  output logic        lcd_wr_n,
  output logic        lcd_dc
);

  localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WR_CYCLES - 1);

  logic          active;
  logic          low;
  logic [CW-1:0] cnt;

  // A new word may enter on the last clock of the high phase, giving back-to-back strobes.
  assign free     = !active || (!low && (cnt == CNT_MAX));
  assign idle     = !active;
  assign lcd_wr_n = !(active && low);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      low      <= 1'b0;
      cnt      <= '0;
      lcd_data <= 16'h0000;
      lcd_dc   <= 1'b1;
    end else if (load && free) begin
      active   <= 1'b1;
      low      <= 1'b1;
      cnt      <= '0;
      lcd_data <= word;
      lcd_dc   <= word_dc;
    end else if (active) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        if (low) low <= 1'b0;
        else     active <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rgb565_lcd_writer.sv
// RGB888 stream to 16-bit 8080 LCD writer: per-frame window preamble, then RGB565 pixels.
// Optional colour-bar generator enabled by defining TEST_PATTERN_EN.
module rgb565_lcd_writer
  import rgb565_lcd_pkg::*;
#(
  parameter int H_RES     = 480,
  parameter int V_RES     = 320,
  parameter int WR_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [23:0] i_tdata,
  input  logic        i_tvalid,
  output logic        o_tready,
  input  logic        i_tuser,
  input  logic        i_tlast,
`ifdef TEST_PATTERN_EN
  input  logic        i_pattern_en,
`endif
  output logic [15:0] o_lcd_data,
  output logic        o_lcd_wr_n,
  output logic        o_lcd_dc,
  output logic        o_lcd_cs_n,
  output logic        o_busy,
  output logic        o_frame_err,
  output logic [1:0]  o_state
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_MAX     = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(V_RES - 1);
  localparam logic [15:0]   H_END     = 16'(H_RES - 1);
  localparam logic [15:0]   V_END     = 16'(V_RES - 1);
  localparam logic [3:0]    PRE_LAST  = 4'(PRE_LEN - 1);
  localparam logic [XW-1:0] CAP_X     = (H_RES == 1) ? XW'(0) : XW'(1);
  localparam logic [YW-1:0] CAP_Y     = (H_RES == 1 && V_RES > 1) ? YW'(1) : YW'(0);
  localparam logic          PEND_LAST = (H_RES == 1 && V_RES == 1);

  state_t        state, n_state;
  logic [XW-1:0] x, n_x;
  logic [YW-1:0] y, n_y;
  logic [3:0]    pre_idx, n_pre;
  logic [15:0]   pix_reg, n_pix;
  logic          pending, n_pending, pend_last, n_pend_last;
  logic          done, n_done, cs_n, n_cs_n, frame_err, run;
  logic          tready, load, word_dc, err, capture, free, idle;
  logic [15:0]   word;
  logic          x_last, y_last;
  logic [XW-1:0] x_adv;
  logic [YW-1:0] y_adv;
  logic          pat_mode;
`ifdef TEST_PATTERN_EN
  logic          n_pat;
  logic [2:0]    bar_idx;
  assign bar_idx = 3'((32'(x) * 8) / H_RES);
`else
  assign pat_mode = 1'b0;
`endif

  function automatic logic [16:0] pre_word(input logic [3:0] idx);
    logic [16:0] w;
    case (idx)
      4'd0:    w = {1'b0, 8'h00, OP_CASET};
      4'd3:    w = {1'b1, 8'h00, H_END[15:8]};
      4'd4:    w = {1'b1, 8'h00, H_END[7:0]};
      4'd5:    w = {1'b0, 8'h00, OP_PASET};
      4'd8:    w = {1'b1, 8'h00, V_END[15:8]};
      4'd9:    w = {1'b1, 8'h00, V_END[7:0]};
      4'd10:   w = {1'b0, 8'h00, OP_RAMWR};
      default: w = {1'b1, 16'h0000};
    endcase
    return w;
  endfunction

  assign x_last = (x == X_MAX);
  assign y_last = (y == Y_MAX);
  assign x_adv  = x_last ? '0 : x + XW'(1);
  assign y_adv  = x_last ? (y_last ? '0 : y + YW'(1)) : y;

  // Stream handshake: a beat transfers on a rising clock edge where i_tvalid and
  // o_tready are both high; o_tready never depends on i_tvalid.
  always_comb begin
    n_state     = state;
    n_x         = x;
    n_y         = y;
    n_pre       = pre_idx;
    n_pix       = pix_reg;
    n_pending   = pending;
    n_pend_last = pend_last;
    n_done      = done;
    n_cs_n      = cs_n;
`ifdef TEST_PATTERN_EN
    n_pat       = pat_mode;
`endif
    tready  = 1'b0;
    load    = 1'b0;
    word    = pix_reg;
    word_dc = 1'b1;
    err     = 1'b0;
    capture = 1'b0;
    case (state)
      ST_IDLE: begin
        tready = run;
        n_cs_n = 1'b1;
`ifdef TEST_PATTERN_EN
        if (run && i_pattern_en) begin
          n_pat     = 1'b1;
          n_state   = ST_CMD;
          n_pre     = '0;
          n_x       = '0;
          n_y       = '0;
          n_pending = 1'b0;
          n_done    = 1'b0;
        end else
`endif
        capture = run && i_tvalid && i_tuser;
      end
      ST_RESYNC: begin
        tready  = 1'b1;
        capture = i_tvalid && i_tuser;
        if (idle && !capture) n_cs_n = 1'b1;
      end
      ST_CMD: begin
        tready = pat_mode;
        if (free) begin
          load              = 1'b1;
          {word_dc, word}   = pre_word(pre_idx);
          n_cs_n            = 1'b0;
          if (pre_idx == PRE_LAST) n_state = ST_PIX;
          else                     n_pre   = pre_idx + 4'd1;
        end
      end
      ST_PIX: begin
        if (done) begin
          tready = pat_mode;
          if (idle) begin
            n_state = ST_IDLE;
            n_cs_n  = 1'b1;
            n_done  = 1'b0;
`ifdef TEST_PATTERN_EN
            n_pat   = 1'b0;
`endif
          end
        end
`ifdef TEST_PATTERN_EN
        else if (pat_mode) begin
          tready = 1'b1;
          if (free) begin
            load   = 1'b1;
            word   = bar_color(bar_idx);
            n_x    = x_adv;
            n_y    = y_adv;
            n_done = x_last && y_last;
          end
        end
`endif
        else if (pending) begin
          if (free) begin
            load      = 1'b1;
            n_pending = 1'b0;
            n_done    = pend_last;
          end
        end else begin
          tready = free;
          if (i_tvalid && free) begin
            if (i_tuser) begin
              err     = 1'b1;
              capture = 1'b1;
            end else if (i_tlast != x_last) begin
              err     = 1'b1;
              n_state = ST_RESYNC;
            end else begin
              load   = 1'b1;
              word   = rgb888_to_565(i_tdata);
              n_x    = x_adv;
              n_y    = y_adv;
              n_done = x_last && y_last;
            end
          end
        end
      end
      default: n_state = ST_IDLE;
    endcase
    // The SOF pixel is held back until the preamble has been written.
    if (capture) begin
      n_pix       = rgb888_to_565(i_tdata);
      n_pending   = 1'b1;
      n_pend_last = PEND_LAST;
      n_x         = CAP_X;
      n_y         = CAP_Y;
      n_pre       = '0;
      n_done      = 1'b0;
      n_state     = ST_CMD;
`ifdef TEST_PATTERN_EN
      n_pat       = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      x         <= '0;
      y         <= '0;
      pre_idx   <= '0;
      pix_reg   <= 16'h0000;
      pending   <= 1'b0;
      pend_last <= 1'b0;
      done      <= 1'b0;
      cs_n      <= 1'b1;
      frame_err <= 1'b0;
      run       <= 1'b0;
`ifdef TEST_PATTERN_EN
      pat_mode  <= 1'b0;
`endif
    end else begin
      state     <= n_state;
      x         <= n_x;
      y         <= n_y;
      pre_idx   <= n_pre;
      pix_reg   <= n_pix;
      pending   <= n_pending;
      pend_last <= n_pend_last;
      done      <= n_done;
      cs_n      <= n_cs_n;
      frame_err <= err;
      run       <= 1'b1;
`ifdef TEST_PATTERN_EN
      pat_mode  <= n_pat;
`endif
    end
  end

  lcd_write_strobe #(.WR_CYCLES(WR_CYCLES)) u_strobe (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (load),
    .word     (word),
    .word_dc  (word_dc),
    .free     (free),
    .idle     (idle),
    .lcd_data (o_lcd_data),
    .lcd_wr_n (o_lcd_wr_n),
    .lcd_dc   (o_lcd_dc)
  );

  assign o_tready    = tready;
  assign o_lcd_cs_n  = cs_n;
  assign o_busy      = (state != ST_IDLE);
  assign o_frame_err = frame_err;
  assign o_state     = state;

endmodule
